bulk_read_arbiter: RTL and testbench

BULK_READ_ARBITER -- requirements
Module: bulk_read_arbiter

---
 rtl/bulk_read_arbiter_pkg.sv | 25 ++
 rtl/bulk_read_interface.sv | 29 ++
 rtl/bulk_read_arbiter.sv | 110 +++++++++++
 tb/tb_bulk_read_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bulk_read_arbiter_pkg.sv
// Shared memory-side package for the bulk-read (cache line) path.
// Holds the arbiter state encoding, the one-bit requester index type,
// default line geometry and a small helper for round-robin tie-breaks.
package bulk_read_arbiter_pkg;

  // Default line geometry used by the caches and the AXI line adapter.
  localparam int unsigned BR_LINE_SIZE = 8;   // beats per line
  localparam int unsigned BR_DATA_W    = 64;  // bits per beat
  localparam int unsigned BR_ADDR_W    = 32;  // request address width

  // Arbiter ownership state.
  typedef enum logic {
    ARB_IDLE = 1'b0,  // no transaction owned
    ARB_BUSY = 1'b1   // one accepted request awaiting its response
  } arb_state_t;

  // Requester index: 0 = instruction cache, 1 = data cache.
  typedef logic port_idx_t;

  // The port that did not win last time.
  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/bulk_read_interface.sv
// Bulk (whole cache line) read/write request/response channel.
// Request: req_valid/req_ready handshake carrying write flag, address,
// a full line of write data and per-byte strobes.
// Response: single-cycle resp_valid pulse with a full line of read data.
// Modports: master issues requests, slave accepts them.
interface bulk_read_interface #(
  parameter int unsigned LINE_SIZE = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 32
);
  logic                                     req_valid;
  logic                                     req_ready;
  logic                                     req_write;
  logic [ADDR_W-1:0]                        req_addr;
  logic [LINE_SIZE-1:0][DATA_W-1:0]         req_wdata;
  logic [LINE_SIZE-1:0][DATA_W/8-1:0]       req_wstrb;
  logic                                     resp_valid;
  logic [LINE_SIZE-1:0][DATA_W-1:0]         resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bulk_read_arbiter.sv
// Two-to-one arbiter for the bulk line port: instruction cache (req0) and
// data cache (req1) share one downstream line port (mem_out).
// At most one mem_out transaction is outstanding. Ties alternate between
// ports; a request stalled by mem_out.req_ready keeps its grant until it
// is accepted. Responses go to the owning port only; rdata is broadcast.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   req0    - requester 0 (instruction cache), slave side
//   req1    - requester 1 (data cache), slave side
//   mem_out - shared downstream line port, master side
module bulk_read_arbiter
  import bulk_read_arbiter_pkg::*;
#(
  parameter int unsigned LINE_SIZE = BR_LINE_SIZE,
  parameter int unsigned DATA_W    = BR_DATA_W,
  parameter int unsigned ADDR_W    = BR_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  bulk_read_interface.slave  req0,
  bulk_read_interface.slave  req1,
  bulk_read_interface.master mem_out
);

  arb_state_t state_q;
  port_idx_t  owner_q;
  port_idx_t  last_grant_q;
  port_idx_t  grant_q;
  logic       hold_q;

  port_idx_t                          winner;
  logic                               win_valid;
  logic                               win_write;
  logic [ADDR_W-1:0]                  win_addr;
  logic [LINE_SIZE-1:0][DATA_W-1:0]   win_wdata;
  logic [LINE_SIZE-1:0][DATA_W/8-1:0] win_wstrb;
  logic                               issue_en;
  logic                               req_go;
  logic                               req_fire;
  logic                               resp_take;

  always_comb begin
    winner = 1'b0;
    if (hold_q)
      winner = grant_q;
    else if (req0.req_valid && req1.req_valid)
      winner = other_port(last_grant_q);
    else if (req1.req_valid)
      winner = 1'b1;

    win_valid = winner ? req1.req_valid : req0.req_valid;
    win_write = winner ? req1.req_write : req0.req_write;
    win_addr  = winner ? req1.req_addr  : req0.req_addr;
    win_wdata = winner ? req1.req_wdata : req0.req_wdata;
    win_wstrb = winner ? req1.req_wstrb : req0.req_wstrb;

    // Gating with rst keeps every handshake output low while reset is held.
    issue_en  = (state_q == ARB_IDLE) && rst;
    req_go    = issue_en && win_valid;
    req_fire  = req_go && mem_out.req_ready;
    resp_take = (state_q == ARB_BUSY) && mem_out.resp_valid;

    mem_out.req_valid = req_go;
    mem_out.req_write = win_write;
    mem_out.req_addr  = win_addr;
    mem_out.req_wdata = win_wdata;
    mem_out.req_wstrb = win_wstrb;

    req0.req_ready = issue_en && (winner == 1'b0) && mem_out.req_ready;
    req1.req_ready = issue_en && (winner == 1'b1) && mem_out.req_ready;

    req0.resp_valid = resp_take && (owner_q == 1'b0);
    req1.resp_valid = resp_take && (owner_q == 1'b1);
    req0.resp_rdata = mem_out.resp_rdata;
    req1.resp_rdata = mem_out.resp_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_fire) begin
            state_q      <= ARB_BUSY;
            owner_q      <= winner;
            last_grant_q <= winner;
            hold_q       <= 1'b0;
          end else begin
            // Pin the grant while the winner's request is stalled; a winner
            // that drops req_valid releases the hold on the next edge.
            hold_q  <= req_go;
            grant_q <= winner;
          end
        end
        ARB_BUSY: begin
          if (mem_out.resp_valid)
            state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bulk_read_arbiter.sv
module tb_bulk_read_arbiter;
  localparam int unsigned LS = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [LS-1:0][DW-1:0]   line_a;
  logic [LS-1:0][DW-1:0]   wd;
  logic [LS-1:0][DW/8-1:0] ws;

  bulk_read_interface #(.LINE_SIZE(LS), .DATA_W(DW), .ADDR_W(AW)) r0 ();
  bulk_read_interface #(.LINE_SIZE(LS), .DATA_W(DW), .ADDR_W(AW)) r1 ();
  bulk_read_interface #(.LINE_SIZE(LS), .DATA_W(DW), .ADDR_W(AW)) mo ();

  bulk_read_arbiter #(.LINE_SIZE(LS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (r0),
    .req1    (r1),
    .mem_out (mo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    r0.req_valid = 1'b0; r0.req_write = 1'b0; r0.req_addr = '0; r0.req_wdata = '0; r0.req_wstrb = '0;
    r1.req_valid = 1'b0; r1.req_write = 1'b0; r1.req_addr = '0; r1.req_wdata = '0; r1.req_wstrb = '0;
    mo.req_ready = 1'b0; mo.resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    for (int unsigned i = 0; i < LS; i++) begin
      line_a[i] = DW'(i);
      wd[i]     = 64'hA5A5_0000_0000_0000 | DW'(i);
    end
    ws = 64'hFF00_F0F0_0F0F_00FF;
    clear_inputs();
    mo.resp_rdata = '0;

    // Reset: all handshake outputs low even with live inputs.
    r0.req_valid = 1'b1; r1.req_valid = 1'b1; mo.req_ready = 1'b1; mo.resp_valid = 1'b1;
    cyc(); cyc(); settle();
    check("rst_mvalid", 512'(mo.req_valid), 512'(0));
    check("rst_r0rdy",  512'(r0.req_ready), 512'(0));
    check("rst_r1rdy",  512'(r1.req_ready), 512'(0));
    check("rst_r0resp", 512'(r0.resp_valid), 512'(0));
    check("rst_r1resp", 512'(r1.resp_valid), 512'(0));
    clear_inputs();
    rst = 1'b1;

    // Single read from port 0, response five cycles after acceptance.
    cyc();
    r0.req_valid = 1'b1; r0.req_addr = 32'h1000; mo.req_ready = 1'b1;
    settle();
    check("t1_mvalid", 512'(mo.req_valid), 512'(1));
    check("t1_maddr",  512'(mo.req_addr),  512'(32'h1000));
    check("t1_r0rdy",  512'(r0.req_ready), 512'(1));
    check("t1_r1rdy",  512'(r1.req_ready), 512'(0));
    cyc();
    r0.req_valid = 1'b0; mo.req_ready = 1'b0;
    settle();
    check("t1_busy_mvalid", 512'(mo.req_valid), 512'(0));
    for (int k = 0; k < 3; k++) begin
      cyc(); settle();
      check("t1_wait_r0resp", 512'(r0.resp_valid), 512'(0));
      check("t1_wait_r1resp", 512'(r1.resp_valid), 512'(0));
    end
    cyc();
    mo.resp_valid = 1'b1; mo.resp_rdata = line_a;
    settle();
    check("t1_r0resp",  512'(r0.resp_valid), 512'(1));
    check("t1_r0rdata", 512'(r0.resp_rdata), 512'(line_a));
    check("t1_r1resp",  512'(r1.resp_valid), 512'(0));
    check("t1_r1rdata", 512'(r1.resp_rdata), 512'(line_a));
    cyc();
    mo.resp_valid = 1'b0;
    settle();

    // Tie after reset: port 0 first, port 1 after a one-cycle bubble.
    do_reset();
    cyc();
    r0.req_valid = 1'b1; r0.req_addr = 32'h1000;
    r1.req_valid = 1'b1; r1.req_addr = 32'h2000;
    mo.req_ready = 1'b1;
    settle();
    check("t2_first_addr", 512'(mo.req_addr),  512'(32'h1000));
    check("t2_r0rdy",      512'(r0.req_ready), 512'(1));
    check("t2_r1rdy",      512'(r1.req_ready), 512'(0));
    cyc();
    r0.req_valid = 1'b0;
    settle();
    check("t2_busy_mvalid", 512'(mo.req_valid), 512'(0));
    check("t2_busy_r1rdy",  512'(r1.req_ready), 512'(0));
    cyc();
    mo.resp_valid = 1'b1;
    settle();
    check("t2_r0resp",       512'(r0.resp_valid), 512'(1));
    check("t2_r1resp",       512'(r1.resp_valid), 512'(0));
    check("t2_bubble_mvalid", 512'(mo.req_valid), 512'(0));
    cyc();
    mo.resp_valid = 1'b0;
    settle();
    check("t2_second_mvalid", 512'(mo.req_valid), 512'(1));
    check("t2_second_addr",   512'(mo.req_addr),  512'(32'h2000));
    check("t2_second_r1rdy",  512'(r1.req_ready), 512'(1));
    cyc();
    r1.req_valid = 1'b0;
    cyc();
    mo.resp_valid = 1'b1;
    settle();
    check("t2_r1resp2", 512'(r1.resp_valid), 512'(1));
    check("t2_r0resp2", 512'(r0.resp_valid), 512'(0));
    cyc();
    mo.resp_valid = 1'b0;
    settle();

    // Held grant: port 1 write stalled three cycles while port 0 arrives.
    r1.req_valid = 1'b1; r1.req_write = 1'b1; r1.req_addr = 32'h3000;
    r1.req_wdata = wd; r1.req_wstrb = ws;
    mo.req_ready = 1'b0;
    settle();
    check("t3_addr0",  512'(mo.req_addr),  512'(32'h3000));
    check("t3_write0", 512'(mo.req_write), 512'(1));
    cyc();
    r0.req_valid = 1'b1; r0.req_addr = 32'h4000;
    settle();
    check("t3_addr1",  512'(mo.req_addr),  512'(32'h3000));
    check("t3_wdata1", 512'(mo.req_wdata), 512'(wd));
    check("t3_wstrb1", 512'(mo.req_wstrb), 512'(ws));
    check("t3_r0rdy1", 512'(r0.req_ready), 512'(0));
    cyc(); settle();
    check("t3_addr2",  512'(mo.req_addr),  512'(32'h3000));
    check("t3_r0rdy2", 512'(r0.req_ready), 512'(0));
    cyc();
    mo.req_ready = 1'b1;
    settle();
    check("t3_addr3",  512'(mo.req_addr),  512'(32'h3000));
    check("t3_r1rdy3", 512'(r1.req_ready), 512'(1));
    check("t3_r0rdy3", 512'(r0.req_ready), 512'(0));
    cyc();
    r1.req_valid = 1'b0; r1.req_write = 1'b0; mo.req_ready = 1'b0;
    cyc();
    mo.resp_valid = 1'b1;
    settle();
    check("t3_r1resp", 512'(r1.resp_valid), 512'(1));
    cyc();
    mo.resp_valid = 1'b0; mo.req_ready = 1'b1;
    settle();
    check("t3_next_addr",  512'(mo.req_addr),  512'(32'h4000));
    check("t3_next_r0rdy", 512'(r0.req_ready), 512'(1));
    cyc();
    r0.req_valid = 1'b0; mo.req_ready = 1'b0;
    cyc();
    mo.resp_valid = 1'b1;
    cyc();
    mo.resp_valid = 1'b0;
    settle();

    // Fairness: both ports continuously valid for six transactions.
    do_reset();
    cyc();
    r0.req_valid = 1'b1; r0.req_addr = 32'h5000;
    r1.req_valid = 1'b1; r1.req_addr = 32'h6000;
    mo.req_ready = 1'b1;
    settle();
    for (int t = 0; t < 6; t++) begin
      check("fair_grant", 512'(mo.req_addr), 512'((t % 2 == 1) ? 32'h6000 : 32'h5000));
      cyc();
      mo.resp_valid = 1'b1;
      settle();
      check("fair_resp", 512'((t % 2 == 1) ? r1.resp_valid : r0.resp_valid), 512'(1));
      cyc();
      mo.resp_valid = 1'b0;
      settle();
    end
    r0.req_valid = 1'b0; r1.req_valid = 1'b0; mo.req_ready = 1'b0;

    // Reset while busy for port 1, then a stray response after release.
    cyc();
    r1.req_valid = 1'b1; r1.req_addr = 32'h7000; mo.req_ready = 1'b1;
    settle();
    check("t5_r1rdy", 512'(r1.req_ready), 512'(1));
    cyc();
    r1.req_valid = 1'b0; mo.req_ready = 1'b0;
    settle();
    rst = 1'b0;
    r0.req_valid = 1'b1; mo.req_ready = 1'b1; mo.resp_valid = 1'b1;
    settle();
    check("t5_rst_mvalid", 512'(mo.req_valid),  512'(0));
    check("t5_rst_r0rdy",  512'(r0.req_ready),  512'(0));
    check("t5_rst_r1resp", 512'(r1.resp_valid), 512'(0));
    clear_inputs();
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    mo.resp_valid = 1'b1;
    settle();
    check("t5_stray_r0resp", 512'(r0.resp_valid), 512'(0));
    check("t5_stray_r1resp", 512'(r1.resp_valid), 512'(0));
    cyc();
    mo.resp_valid = 1'b0;
    r0.req_valid = 1'b1; r0.req_addr = 32'h1000;
    r1.req_valid = 1'b1; r1.req_addr = 32'h2000;
    mo.req_ready = 1'b1;
    settle();
    check("t5_tie_mvalid", 512'(mo.req_valid), 512'(1));
    check("t5_tie_addr",   512'(mo.req_addr),  512'(32'h1000));
    cyc();
    clear_inputs();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
